// File: rtl/sram_ctrl.sv
// Controller for an external asynchronous 16-bit SRAM: one read or write per request,
// fixed wait-state timing, every pin driven from a register.
module sram_ctrl #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address_i,
    input  logic [15:0]       data_i,
    input  logic              rden_i,
    input  logic              wren_i,
    output logic [15:0]       data_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire logic [15:0]  sram_dq_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdDone,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] wdata_q;
    logic        dq_oe_q;

    logic unused_addr;
    assign unused_addr = ^address_i[31:ADDR_W];

    assign sram_dq_io = dq_oe_q ? wdata_q : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            wdata_q     <= 16'h0000;
            dq_oe_q     <= 1'b0;
            data_o      <= 16'h0000;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            sram_addr_o <= '0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_ub_n_o <= 1'b1;
            sram_lb_n_o <= 1'b1;
        end else begin
            ready_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Write has priority; a simultaneous read is dropped.
                    if (wren_i) begin
                        state_q     <= StWrSetup;
                        sram_addr_o <= address_i[ADDR_W-1:0];
                        wdata_q     <= data_i;
                        dq_oe_q     <= 1'b1;
                        busy_o      <= 1'b1;
                        sram_ce_n_o <= 1'b0;
                        sram_ub_n_o <= 1'b0;
                        sram_lb_n_o <= 1'b0;
                    end else if (rden_i) begin
                        state_q     <= StRd;
                        sram_addr_o <= address_i[ADDR_W-1:0];
                        cnt_q       <= RD_LOAD;
                        busy_o      <= 1'b1;
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        sram_ub_n_o <= 1'b0;
                        sram_lb_n_o <= 1'b0;
                    end
                end
                StRd: begin
                    if (cnt_q == 4'd0) begin
                        data_o      <= sram_dq_io;
                        ready_o     <= 1'b1;
                        state_q     <= StRdDone;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_ub_n_o <= 1'b1;
                        sram_lb_n_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRdDone: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
                StWrSetup: begin
                    state_q     <= StWrPulse;
                    cnt_q       <= WR_LOAD;
                    sram_we_n_o <= 1'b0;
                end
                StWrPulse: begin
                    // WE rises while address and data are still held for the hold cycle.
                    if (cnt_q == 4'd0) begin
                        sram_we_n_o <= 1'b1;
                        ready_o     <= 1'b1;
                        state_q     <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWrHold: begin
                    state_q     <= StIdle;
                    busy_o      <= 1'b0;
                    dq_oe_q     <= 1'b0;
                    sram_ce_n_o <= 1'b1;
                    sram_ub_n_o <= 1'b1;
                    sram_lb_n_o <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural async SRAM on the DQ bus; the pulldown
// makes an undriven bus read as zero.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [15:0] data_in;
    logic        rden;
    logic        wren;
    logic [15:0] data_out;
    logic        ready;
    logic        busy;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];
    logic        model_drv;

    sram_ctrl #(
        .ADDR_W (18),
        .RD_WAIT(2),
        .WR_WAIT(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address_i  (address),
        .data_i     (data_in),
        .rden_i     (rden),
        .wren_i     (wren),
        .data_o     (data_out),
        .ready_o    (ready),
        .busy_o     (busy),
        .sram_addr_o(sram_addr),
        .sram_dq_io (dq),
        .sram_ce_n_o(ce_n),
        .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n),
        .sram_ub_n_o(ub_n),
        .sram_lb_n_o(lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign model_drv = !ce_n && !oe_n && we_n;
    assign dq = model_drv ? mem[sram_addr] : 16'hzzzz;
    pulldown (dq);

    always @(posedge we_n) begin
        if (!ce_n) mem[sram_addr] <= dq;
    end

    // Bus contention: the controller may only drive DQ with CE low and OE high.
    always @(negedge clk) begin
        checks++;
        if ((!oe_n && !we_n) || (!model_drv && dq != 16'h0000 && (!oe_n || ce_n))) begin
            errors++;
            $display("FAIL contention: oe_n=%b we_n=%b ce_n=%b dq=%h, required no DUT drive with OE low",
                     oe_n, we_n, ce_n, dq);
        end
    end

    int          lat;
    int          we_low;
    int          oe_low;
    logic [17:0] pin_addr;
    logic        busy1;

    // Issue one request at a negedge and observe until ready (bounded at 20 cycles).
    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [15:0] d);
        wren    = w;
        rden    = r;
        address = a;
        data_in = d;
        lat     = 0;
        we_low  = 0;
        oe_low  = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                wren     = 1'b0;
                rden     = 1'b0;
                pin_addr = sram_addr;
                busy1    = busy;
            end
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (ready) break;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rden    = 1'b1;
        wren    = 1'b0;
        address = 32'h0000_0040;
        data_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || dq !== 16'h0000 ||
                ready !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000 ||
                sram_addr !== 18'h0) begin
                errors++;
                $display("FAIL reset: pins=%b dq=%h ready=%b busy=%b data=%h addr=%h, required 11111 0000 0 0 0000 0",
                         {ce_n, oe_n, we_n, ub_n, lb_n}, dq, ready, busy, data_out, sram_addr);
            end
        end
        rden  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ce_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%b ce_n=%b, required 0 1", busy, ce_n);
        end
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b0, 32'h0000_0123, 16'hA5C3);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL wr_latency: got %0d, required 4", lat);
        end
        checks++;
        if (we_low != 2 || oe_low != 0) begin
            errors++;
            $display("FAIL wr_strobes: we_low=%0d oe_low=%0d, required 2 0", we_low, oe_low);
        end
        checks++;
        if (pin_addr !== 18'h00123 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept: addr=%h busy=%b, required 00123 1", pin_addr, busy1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || ce_n !== 1'b1 || dq !== 16'h0000) begin
            errors++;
            $display("FAIL wr_end: busy=%b ready=%b ce_n=%b dq=%h, required 0 0 1 0000",
                     busy, ready, ce_n, dq);
        end
        do_access(1'b0, 1'b1, 32'h0000_0123, 16'h0000);
        checks++;
        if (lat != 3 || data_out !== 16'hA5C3) begin
            errors++;
            $display("FAIL rd_basic: lat=%0d data=%h, required 3 a5c3", lat, data_out);
        end
        checks++;
        if (we_low != 0) begin
            errors++;
            $display("FAIL rd_we: we_low=%0d, required 0", we_low);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        int pulses;
        do_access(1'b1, 1'b1, 32'h0007_FFFF, 16'hFFFF);
        checks++;
        if (lat != 4 || we_low != 2) begin
            errors++;
            $display("FAIL prio_write: lat=%0d we_low=%0d, required 4 2", lat, we_low);
        end
        checks++;
        if (pin_addr !== 18'h3FFFF) begin
            errors++;
            $display("FAIL addr_map: got %h, required 3ffff", pin_addr);
        end
        checks++;
        if (data_out !== 16'hA5C3) begin
            errors++;
            $display("FAIL data_hold_on_write: got %h, required a5c3", data_out);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL prio_single_pulse: extra pulses %0d, required 0", pulses);
        end
        do_access(1'b0, 1'b1, 32'h0007_FFFF, 16'h0000);
        checks++;
        if (lat != 3 || data_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL prio_readback: lat=%0d data=%h, required 3 ffff", lat, data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          nready;
        int          cyc;
        int          last;
        logic        prev_ready;
        logic [31:0] exp_addr;
        logic [15:0] exp_data;
        do_access(1'b1, 1'b0, 32'h0000_0010, 16'h1111);
        @(negedge clk);
        do_access(1'b1, 1'b0, 32'h0000_0011, 16'h2222);
        @(negedge clk);
        exp_addr   = 32'h10;
        address    = exp_addr;
        rden       = 1'b1;
        nready     = 0;
        cyc        = 0;
        last       = 0;
        prev_ready = 1'b0;
        while (nready < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                nready++;
                exp_data = (exp_addr == 32'h10) ? 16'h1111 : 16'h2222;
                checks++;
                if (data_out !== exp_data) begin
                    errors++;
                    $display("FAIL b2b_data: read %0d got %h, required %h", nready, data_out, exp_data);
                end
                checks++;
                if ((nready == 1 && cyc != 3) || (nready > 1 && cyc - last != 4) || prev_ready) begin
                    errors++;
                    $display("FAIL b2b_timing: read %0d at cycle %0d (prev %0d), required 3 then every 4",
                             nready, cyc, last);
                end
                last     = cyc;
                exp_addr = (exp_addr == 32'h10) ? 32'h11 : 32'h10;
                address  = exp_addr;
                if (nready == 3) rden = 1'b0;
            end
            prev_ready = ready;
        end
        checks++;
        if (nready != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d reads, required 3", nready);
        end
        rden = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ready=%b busy=%b, required 0 0", ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int pulses;
        wren    = 1'b1;
        address = 32'h0000_0200;
        data_in = 16'h5555;
        @(negedge clk);
        wren = 1'b0;
        @(negedge clk);
        checks++;
        if (we_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_entry: we_n=%b, required 0", we_n);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (we_n !== 1'b1 || ce_n !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 ||
            dq !== 16'h0000 || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: we_n=%b ce_n=%b ready=%b busy=%b dq=%h data=%h, required 1 1 0 0 0000 0000",
                     we_n, ce_n, ready, busy, dq, data_out);
        end
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: pulses=%0d busy=%b, required 0 0", pulses, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
